// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, datapath select codes,
// opcode/funct constants and the decoded-instruction record.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsRAlu,
    ClsIAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJ,
    ClsJal,
    ClsJr,
    ClsJalr,
    ClsIllegal
  } cls_e;

  localparam logic [3:0] AluNop  = 4'h0;
  localparam logic [3:0] AluAdd  = 4'h1;
  localparam logic [3:0] AluSub  = 4'h2;
  localparam logic [3:0] AluAnd  = 4'h3;
  localparam logic [3:0] AluOr   = 4'h4;
  localparam logic [3:0] AluSlt  = 4'h5;
  localparam logic [3:0] AluSltu = 4'h6;
  localparam logic [3:0] AluNor  = 4'h7;
  localparam logic [3:0] AluSll  = 4'h8;
  localparam logic [3:0] AluSrl  = 4'h9;
  localparam logic [3:0] AluLui  = 4'hA;
  localparam logic [3:0] AluXor  = 4'hB;

  localparam logic [1:0] NpcPc4 = 2'b00;
  localparam logic [1:0] NpcBr  = 2'b01;
  localparam logic [1:0] NpcJ   = 2'b10;
  localparam logic [1:0] NpcJr  = 2'b11;

  localparam logic [1:0] GprRd = 2'b00;
  localparam logic [1:0] GprRt = 2'b01;
  localparam logic [1:0] Gpr31 = 2'b10;

  localparam logic [1:0] WdAlu = 2'b00;
  localparam logic [1:0] WdMem = 2'b01;
  localparam logic [1:0] WdPc  = 2'b10;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  typedef struct packed {
    cls_e       cls;
    logic       is_bne;
    logic [3:0] alu_op;
    logic       ext_op;
    logic       alu_src;
    logic       alu_a;
    logic [1:0] gpr_sel;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction decoder: Op/Funct to instruction class plus the EX-stage
// ALU controls and the write-back register select.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output dec_t       o_dec,
  output logic       o_illegal
);

  always_comb begin
    o_dec         = '0;
    o_dec.cls     = ClsIllegal;
    o_dec.alu_op  = AluNop;
    o_dec.gpr_sel = GprRd;
    case (i_op)
      OpRtype: begin
        o_dec.cls = ClsRAlu;
        case (i_funct)
          FnAdd, FnAddu: o_dec.alu_op = AluAdd;
          FnSub, FnSubu: o_dec.alu_op = AluSub;
          FnAnd:         o_dec.alu_op = AluAnd;
          FnOr:          o_dec.alu_op = AluOr;
          FnXor:         o_dec.alu_op = AluXor;
          FnNor:         o_dec.alu_op = AluNor;
          FnSlt:         o_dec.alu_op = AluSlt;
          FnSltu:        o_dec.alu_op = AluSltu;
          // Immediate shifts take A from shamt; the variable forms keep A = rs.
          FnSll: begin
            o_dec.alu_op = AluSll;
            o_dec.alu_a  = 1'b1;
          end
          FnSrl: begin
            o_dec.alu_op = AluSrl;
            o_dec.alu_a  = 1'b1;
          end
          FnSllv:        o_dec.alu_op = AluSll;
          FnSrlv:        o_dec.alu_op = AluSrl;
          FnJr:          o_dec.cls    = ClsJr;
          FnJalr:        o_dec.cls    = ClsJalr;
          default:       o_dec.cls    = ClsIllegal;
        endcase
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
        o_dec.cls     = ClsIAlu;
        o_dec.alu_src = 1'b1;
        o_dec.gpr_sel = GprRt;
        o_dec.ext_op  = 1'b1;
        case (i_op)
          OpAddi, OpAddiu: o_dec.alu_op = AluAdd;
          OpSlti:          o_dec.alu_op = AluSlt;
          OpSltiu:         o_dec.alu_op = AluSltu;
          OpLui:           o_dec.alu_op = AluLui;
          OpAndi: begin
            o_dec.alu_op = AluAnd;
            o_dec.ext_op = 1'b0;
          end
          OpOri: begin
            o_dec.alu_op = AluOr;
            o_dec.ext_op = 1'b0;
          end
          default: begin
            o_dec.alu_op = AluXor;
            o_dec.ext_op = 1'b0;
          end
        endcase
      end
      OpLw, OpSw: begin
        o_dec.cls     = (i_op == OpLw) ? ClsLoad : ClsStore;
        o_dec.alu_op  = AluAdd;
        o_dec.alu_src = 1'b1;
        o_dec.ext_op  = 1'b1;
        o_dec.gpr_sel = GprRt;
      end
      OpBeq, OpBne: begin
        o_dec.cls    = ClsBranch;
        o_dec.is_bne = (i_op == OpBne);
        o_dec.alu_op = AluSub;
        o_dec.ext_op = 1'b1;
      end
      OpJ:     o_dec.cls = ClsJ;
      OpJal:   o_dec.cls = ClsJal;
      default: o_dec.cls = ClsIllegal;
    endcase
  end

  assign o_illegal = (o_dec.cls == ClsIllegal);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB/HALT) with memory wait states and illegal trap.
// Define MC_CTRL_PERF_EN to add saturating cyc_cnt/instr_cnt performance counters.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT         = 0,
  parameter int unsigned TRAP_ON_ILLEGAL = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             EXTOp,
  output logic [3:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic             ALUSrc,
  output logic             ALU_A,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic [2:0]       state,
  output logic             illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam logic [7:0] LatCnt = 8'(MEM_LAT);

  state_e     r_state;
  state_e     w_state_d;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_d;
  dec_t       w_dec;
  logic       w_dec_illegal;
  logic       w_mem_done;

  mc_ctrl_dec u_dec (
    .i_op      (Op),
    .i_funct   (Funct),
    .o_dec     (w_dec),
    .o_illegal (w_dec_illegal)
  );

  // Early mem_ready is ignored until the wait count has run out.
  assign w_mem_done = (r_wait_cnt == LatCnt) && mem_ready;

  always_comb begin
    w_state_d = r_state;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    EXTOp     = 1'b0;
    ALUOp     = AluNop;
    NPCOp     = NpcPc4;
    ALUSrc    = 1'b0;
    ALU_A     = 1'b0;
    GPRSel    = GprRd;
    WDSel     = WdAlu;
    illegal   = 1'b0;
    case (r_state)
      S_IF: begin
        MemRead = 1'b1;
        if (w_mem_done) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          w_state_d = S_ID;
        end
      end
      S_ID: begin
        if (w_dec_illegal) begin
          illegal   = 1'b1;
          w_state_d = (TRAP_ON_ILLEGAL != 0) ? S_HALT : S_IF;
        end else begin
          case (w_dec.cls)
            ClsJ: begin
              PCWrite   = 1'b1;
              NPCOp     = NpcJ;
              w_state_d = S_IF;
            end
            ClsJal: begin
              PCWrite   = 1'b1;
              NPCOp     = NpcJ;
              RegWrite  = 1'b1;
              GPRSel    = Gpr31;
              WDSel     = WdPc;
              w_state_d = S_IF;
            end
            ClsJr: begin
              PCWrite   = 1'b1;
              NPCOp     = NpcJr;
              w_state_d = S_IF;
            end
            ClsJalr: begin
              PCWrite   = 1'b1;
              NPCOp     = NpcJr;
              RegWrite  = 1'b1;
              GPRSel    = GprRd;
              WDSel     = WdPc;
              w_state_d = S_IF;
            end
            default: w_state_d = S_EX;
          endcase
        end
      end
      S_EX: begin
        EXTOp  = w_dec.ext_op;
        ALUOp  = w_dec.alu_op;
        ALUSrc = w_dec.alu_src;
        ALU_A  = w_dec.alu_a;
        case (w_dec.cls)
          ClsBranch: begin
            NPCOp     = NpcBr;
            PCWrite   = w_dec.is_bne ? ~Zero : Zero;
            w_state_d = S_IF;
          end
          ClsLoad, ClsStore: w_state_d = S_MEM;
          default:           w_state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (w_dec.cls == ClsStore) begin
          MemWrite = 1'b1;
        end else begin
          MemRead = 1'b1;
        end
        if (w_mem_done) begin
          w_state_d = (w_dec.cls == ClsStore) ? S_IF : S_WB;
        end
      end
      S_WB: begin
        RegWrite  = 1'b1;
        WDSel     = (w_dec.cls == ClsLoad) ? WdMem : WdAlu;
        GPRSel    = w_dec.gpr_sel;
        w_state_d = S_IF;
      end
      S_HALT: w_state_d = S_HALT;
      default: w_state_d = S_IF;
    endcase
    // Reset aborts the current state, so no architectural write may escape in that cycle.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_comb begin
    w_wait_d = r_wait_cnt;
    if (w_state_d != r_state) begin
      w_wait_d = '0;
    end else if ((r_state == S_IF || r_state == S_MEM) && r_wait_cnt != LatCnt) begin
      w_wait_d = r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IF;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_d;
    end
  end

  assign state = r_state;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;

  assign w_retire = (w_state_d == S_IF) &&
                    (r_state == S_ID || r_state == S_EX || r_state == S_MEM || r_state == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt   <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != S_HALT && r_cyc_cnt != '1) begin
        r_cyc_cnt <= r_cyc_cnt + 1'b1;
      end
      if (w_retire && r_instr_cnt != '1) begin
        r_instr_cnt <= r_instr_cnt + 1'b1;
      end
    end
  end

  assign cyc_cnt   = r_cyc_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule
